// File: rtl/noc_port_arbiter.sv
// Per-packet arbiter sharing one mesh output port between NUM_REQ on-core sources.
// Two priority classes with round-robin inside each, aging promotion, one-entry output register.
package noc_pkg;

   typedef enum logic [1:0] {
      MSG_STATUS = 2'd0,
      MSG_CLAUSE = 2'd1,
      MSG_FWD    = 2'd2,
      MSG_CTRL   = 2'd3
   } msg_type_e;

   typedef struct packed {
      msg_type_e   msg_type;
      logic [7:0]  src_id;
      logic [7:0]  dst_id;
      logic [7:0]  quality_metric;
      logic [31:0] payload;
   } noc_packet_t;

endpackage

module noc_port_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 3,
   parameter int unsigned CORE_ID     = 0,
   parameter int unsigned HI_Q_THRESH = 8,
   parameter int unsigned AGE_LIMIT   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          port_en,
   input  noc_packet_t [NUM_REQ-1:0]     req_pkt,
   input  logic        [NUM_REQ-1:0]     req_valid,
   output logic        [NUM_REQ-1:0]     req_ready,
   output noc_packet_t                   out_pkt,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic        [NUM_REQ-1:0][15:0] grant_cnt
);

   localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0]  AgeMax = 4'(AGE_LIMIT);
   localparam logic [7:0]  SrcId  = 8'(CORE_ID);

   logic [PtrW-1:0]            hi_ptr_q, lo_ptr_q;
   logic [NUM_REQ-1:0][3:0]    age_q;

   logic [NUM_REQ-1:0]         hi_cls, lo_cls, promo;
   logic                       slot_free, grant_en;
   logic                       found, win_hi;
   logic [PtrW-1:0]            win_idx, rr_idx, nxt_ptr;
   logic [NUM_REQ-1:0]         grant_vec;
   noc_packet_t                win_pkt;

   // Class is recomputed every cycle from the packet currently presented.
   always_comb begin
      hi_cls = '0;
      lo_cls = '0;
      promo  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hi_cls[i] = req_valid[i] && (32'(req_pkt[i].quality_metric) >= HI_Q_THRESH);
         lo_cls[i] = req_valid[i] && !hi_cls[i];
         promo[i]  = lo_cls[i] && (age_q[i] == AgeMax);
      end
   end

   always_comb begin
      found   = 1'b0;
      win_hi  = 1'b0;
      win_idx = '0;
      rr_idx  = '0;
      // Descending scan so the lowest promoted index is the last one assigned.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (promo[i]) begin
            win_idx = PtrW'(i);
            found   = 1'b1;
         end
      end
      if (!found) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = PtrW'((int'(hi_ptr_q) + k) % NUM_REQ);
            if (!found && hi_cls[rr_idx]) begin
               win_idx = rr_idx;
               win_hi  = 1'b1;
               found   = 1'b1;
            end
         end
      end
      if (!found) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = PtrW'((int'(lo_ptr_q) + k) % NUM_REQ);
            if (!found && lo_cls[rr_idx]) begin
               win_idx = rr_idx;
               found   = 1'b1;
            end
         end
      end
   end

   assign slot_free = !out_valid || out_ready;
   assign grant_en  = rst_n && slot_free && port_en && (|req_valid);
   assign grant_vec = grant_en ? (NUM_REQ'(1) << win_idx) : '0;
   assign req_ready = grant_vec;
   assign nxt_ptr   = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

   always_comb begin
      win_pkt        = req_pkt[win_idx];
      win_pkt.src_id = SrcId;
   end

   // Output holding register: reload on grant, otherwise drain when the port accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pkt   <= '0;
      end else if (grant_en) begin
         out_valid <= 1'b1;
         out_pkt   <= win_pkt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_ptr_q <= '0;
         lo_ptr_q <= '0;
      end else if (grant_en) begin
         if (win_hi) begin
            hi_ptr_q <= nxt_ptr;
         end else begin
            lo_ptr_q <= nxt_ptr;
         end
      end
   end

   // Losing low-class requesters age toward promotion; dropping valid clears the age.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= '0;
      end else begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!req_valid[j]) begin
               age_q[j] <= '0;
            end else if (grant_en) begin
               if (grant_vec[j]) begin
                  age_q[j] <= '0;
               end else if (lo_cls[j] && (age_q[j] < AgeMax)) begin
                  age_q[j] <= age_q[j] + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i] && (grant_cnt[i] != 16'hFFFF)) begin
               grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
         end
      end
   end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Shares one mesh output port (one direction of one core) between NUM_REQ on-core packet sources, e.g. clause-share unit, status broadcaster and forwarding queue.
- Arbitrates per packet in two priority classes, with round-robin inside each class and aging so low-priority sources cannot starve.
- Stamps src_id with CORE_ID and registers the winner into a one-entry output holding register that drives the interconnect's core_tx / core_tx_valid / core_tx_ready triple for that port.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- CORE_ID, 0, value written into src_id of every forwarded packet; width of the src_id field.
- HI_Q_THRESH, 8, a request is high class when quality_metric >= HI_Q_THRESH (unsigned compare).
- AGE_LIMIT, 4, number of grants a waiting low-class requester may lose before it is promoted (1..15).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- port_en  input  1  when 0, no new grants are issued; a packet already held is still delivered.
- req_pkt  input  NUM_REQ x noc_packet_t  per-requester packet.
- req_valid  input  NUM_REQ  per-requester valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- out_pkt  output  noc_packet_t  packet to mesh port (core_tx).
- out_valid  output  1  to core_tx_valid.
- out_ready  input  1  from core_tx_ready.
- grant_cnt  output  NUM_REQ x 16  per-requester accepted-packet counters, saturating.

Behaviour:
- Reset (asynchronous assert, synchronous-release domain):
  - out_valid = 0, out_pkt = 0 (msg_type = MSG_STATUS, all other fields 0).
  - RR pointers = 0, age counters = 0, grant_cnt = 0.
  - req_ready is 0 while rst_n = 0.
- Reset mid-transfer: the held packet is dropped. No requester sees an accept in the reset cycle.
- Slot free (combinational): slot_free = !out_valid || out_ready.
- Grant conditions, all required: slot_free, port_en = 1, and at least one req_valid.
  - At most one req_ready bit is high, and only for a valid requester.
  - req_ready depends combinationally on req_valid and on out_ready.
- Acceptance: a handshake on requester i (req_valid[i] && req_ready[i]) at edge t gives:
  - out_valid = 1 from t+1, so latency is 1 cycle.
  - out_pkt = req_pkt[i] with src_id replaced by CORE_ID; every other field is unmodified.
- Holding: while out_valid && !out_ready, out_pkt and out_valid stay stable and no grant is issued.
- Back-to-back: out_valid && out_ready in the same cycle as a new grant reloads the register, so out_valid stays 1 with no bubble. Full throughput is 1 packet per cycle.
- Drain: out_ready with no grant clears out_valid next cycle.
- Winner selection, evaluated in order:
  1. Promoted requesters (valid, low class, age == AGE_LIMIT): the lowest index wins.
  2. Otherwise, high-class valid requesters: round-robin from hi_ptr.
  3. Otherwise, low-class valid requesters: round-robin from lo_ptr.
- Round-robin search starts at the pointer and wraps modulo NUM_REQ.
- Pointer update on a grant to i:
  - hi_ptr = (i+1) mod NUM_REQ if the winner came from the high class.
  - lo_ptr = (i+1) mod NUM_REQ if it came from the low class or was promoted.
  - The other pointer is unchanged.
- Aging, updated on each grant:
  - For every j != winner with req_valid[j] && low class: age[j] = min(age[j]+1, AGE_LIMIT).
  - The winner's age resets to 0.
  - age[j] resets to 0 on any cycle where req_valid[j] = 0.
  - When no grant happens, ages hold.
- Class is re-evaluated every cycle. A requester whose packet changes class while waiting keeps its age.
- grant_cnt[i] increments on each accept of requester i and saturates at 0xFFFF.
- port_en falling while out_valid = 1: the held packet completes normally. No further accepts occur until port_en = 1.

Test Plan:
- Single requester: req0 sends 3 packets, out_ready = 1, CORE_ID = 5 → out_valid high for 3 consecutive cycles starting 1 cycle after first accept; each src_id = 5, payloads in order; grant_cnt[0] = 3.
- Round-robin: reqs 0,1,2 continuously valid, all quality_metric = 0, out_ready = 1 → accept order 0,1,2,0,1,2; no idle cycles on out_valid.
- Back-pressure: out_ready = 0 for 5 cycles with out_valid = 1 → out_pkt bit-stable; req_ready = 0 on all 5 cycles; first cycle out_ready = 1 → new grant, and the next packet appears on the following cycle.
- Priority and aging, AGE_LIMIT = 4: req0 at quality 10 continuously, req1 at quality 0 continuously → accepts 0,0,0,0,1,0,0,0,0,1; age[1] returns to 0 after its grant.
- port_en = 0 while a packet is held and req1 valid → held packet delivered, then out_valid = 0 and req_ready = 0 until port_en = 1; req1 is accepted in the cycle port_en rises.
- Reset mid-hold: assert rst_n = 0 while out_valid = 1 and out_ready = 0 → out_valid = 0 immediately, without waiting for a clock; after release, grant_cnt = 0 and the first grant goes to the lowest valid index.
